// File: rtl/key_conditioner.sv
// Debounced push-button conditioner: per-key synchronizer, debounce FSM, press/release pulses.
// Optional toggle output enabled by defining KEY_CONDITIONER_TOGGLE_EN.
module key_conditioner #(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [NKEYS-1:0] KEY,
    input  logic [NKEYS-1:0] toggle_clr,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic [NKEYS-1:0] key_toggle
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        UP      = 2'd0,
        WAIT_DN = 2'd1,
        DOWN    = 2'd2,
        WAIT_UP = 2'd3
    } state_t;

    logic [NKEYS-1:0] sync1_q, sync1_d;
    logic [NKEYS-1:0] sync2_q, sync2_d;

    // Buttons are active-low; invert at the first flop so everything downstream is active-high.
    always_comb begin
        sync1_d = ~KEY;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < NKEYS; i++) begin : g_chan
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          s;

        assign s = sync2_q[i];

        // The counter is cleared on every state change, so it never reaches beyond CNT_LAST.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                UP: begin
                    if (s) begin
                        state_d = WAIT_DN;
                        cnt_d   = '0;
                    end
                end
                WAIT_DN: begin
                    if (s) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = DOWN;
                            cnt_d   = '0;
                            press_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = UP;
                        cnt_d   = '0;
                    end
                end
                DOWN: begin
                    if (!s) begin
                        state_d = WAIT_UP;
                        cnt_d   = '0;
                    end
                end
                WAIT_UP: begin
                    if (!s) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d   = UP;
                            cnt_d     = '0;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = DOWN;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = UP;
                    cnt_d   = '0;
                end
            endcase
            level_d = (state_d == DOWN) || (state_d == WAIT_UP);
        end

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                state_q   <= UP;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;

`ifdef KEY_CONDITIONER_TOGGLE_EN
        logic toggle_q, toggle_d;

        // Flips on the same edge the press pulse is launched; a clear overrides the flip.
        always_comb begin
            toggle_d = toggle_q;
            if (toggle_clr[i]) begin
                toggle_d = 1'b0;
            end else if (press_d) begin
                toggle_d = ~toggle_q;
            end
        end

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                toggle_q <= 1'b0;
            end else begin
                toggle_q <= toggle_d;
            end
        end

        assign key_toggle[i] = toggle_q;
`else
        assign key_toggle[i] = 1'b0;
`endif
    end

`ifndef KEY_CONDITIONER_TOGGLE_EN
    logic unused_toggle_clr;
    assign unused_toggle_clr = ^toggle_clr;
`endif

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter NKEYS, default 4: number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: stable cycles required before acceptance (20 ms at 50 MHz); legal minimum 2.
REQ-003 CLOCK_50  input  1: single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1: reset, synchronous and active-high.
REQ-005 KEY  input  NKEYS: raw asynchronous buttons, active-low (0 = pressed).
REQ-006 toggle_clr  input  NKEYS: per-key synchronous clear of key_toggle.
REQ-007 key_level  output  NKEYS: debounced state, active-high (1 = pressed).
REQ-008 key_press  output  NKEYS: one-cycle pulse on accepted press.
REQ-009 key_release  output  NKEYS: one-cycle pulse on accepted release.
REQ-010 key_toggle  output  NKEYS: toggle bit, inverts on each accepted press.

Function
REQ-011 Each channel SHALL pass the inverted KEY bit through a two-flop synchronizer; the second flop output is the sample s.
REQ-012 Each channel SHALL run its own FSM: UP, WAIT_DN, DOWN, WAIT_UP, plus a counter sized ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-013 Transitions UP->WAIT_DN when s=1, and DOWN->WAIT_UP when s=0; both load the counter with 0.
REQ-014 In WAIT_DN with s=1: if counter = DEBOUNCE_CYCLES-1, go to DOWN; otherwise increment the counter.
REQ-015 In WAIT_DN with s=0: return to UP and clear the counter; no output change.
REQ-016 WAIT_UP SHALL mirror WAIT_DN: commit to UP on count-out, or return to DOWN on reversion.
REQ-017 key_level SHALL be 1 in DOWN and WAIT_UP, and 0 in UP and WAIT_DN; it is registered.
REQ-018 key_press SHALL be high for exactly the one cycle after the WAIT_DN->DOWN commit edge; key_release likewise for WAIT_UP->UP.
REQ-019 Latency: a clean raw edge first sampled at clock edge 1 SHALL change key_level after edge DEBOUNCE_CYCLES+3.
REQ-020 A bounce lasting DEBOUNCE_CYCLES or fewer synchronized cycles SHALL produce no output change.
REQ-021 The counter SHALL never wrap; it is bounded by the commit rule.
REQ-022 key_toggle SHALL invert in the cycle key_press is high; toggle_clr SHALL force it to 0, and clear wins over a simultaneous press.
REQ-023 Channels SHALL be fully independent; simultaneous events on several keys are each processed the same cycle.

Reset
REQ-024 While reset=1: synchronizers=0, FSM=UP, counters=0, key_level=0, key_press=0, key_release=0, key_toggle=0.
REQ-025 Reset asserted mid-WAIT or in DOWN SHALL abort the operation with no press or release pulse emitted.
REQ-026 A key held through reset deassertion SHALL be accepted as a new press DEBOUNCE_CYCLES+3 edges later.

Configuration
REQ-027 Macro KEY_CONDITIONER_TOGGLE_EN: when defined, key_toggle and toggle_clr behave per REQ-022.
REQ-028 Without KEY_CONDITIONER_TOGGLE_EN: key_toggle SHALL be constant 0, toggle_clr ignored, and no toggle flops inferred; the port list is unchanged.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 KEY[0] 1->0 clean -> key_level[0]=1 after edge 7; key_press[0] high exactly one cycle; key_toggle[0]=1.
REQ-030 KEY[1] low pulse of 3 cycles, then high -> key_level, key_press and key_toggle for bit 1 stay 0 throughout.
REQ-031 Bouncing release on KEY[2] (0,1,0,1,1,1,1,1...) -> single key_release[2] pulse; key_level[2] falls 7 edges after the last 0->1.
REQ-032 KEY[0] press accepted in the same cycle toggle_clr[0]=1 -> key_toggle[0]=0 and key_press[0]=1.
REQ-033 reset pulsed while KEY[3] in WAIT_DN, KEY[3] held -> all outputs 0 during reset; press accepted 7 edges after reset falls.
REQ-034 KEY[0] and KEY[2] pressed in the same cycle -> key_press[0] and key_press[2] pulse in the same cycle.
